// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit. It uses a radix-2 shift-add multiplier
// and a restoring divider, both working on operand magnitudes.
module muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpRem    = 3'b110;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   b_mag_q;
  logic [XLEN-1:0]   acc_q;
  logic [XLEN-1:0]   lo_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic              b_zero_q;
  logic [CntW-1:0]   cnt_q;

  logic              a_signed;
  logic              b_signed;
  logic              a_neg_in;
  logic              b_neg_in;
  logic              b_zero_in;
  logic              ovf_in;
  logic              special_in;
  logic [XLEN-1:0]   a_mag_in;
  logic [XLEN-1:0]   b_mag_in;
  logic [XLEN-1:0]   early_data;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   acc_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_data;

  // Request decode: signedness, magnitudes and the divide special cases.
  always_comb begin
    a_signed   = (req_op == OpMulh) || (req_op == OpMulhsu) ||
                 (req_op == OpDiv)  || (req_op == OpRem);
    b_signed   = (req_op == OpMulh) || (req_op == OpDiv) || (req_op == OpRem);
    a_neg_in   = a_signed & req_a[XLEN-1];
    b_neg_in   = b_signed & req_b[XLEN-1];
    a_mag_in   = a_neg_in ? -req_a : req_a;
    b_mag_in   = b_neg_in ? -req_b : req_b;
    b_zero_in  = (req_b == '0);
    ovf_in     = ((req_op == OpDiv) || (req_op == OpRem)) &&
                 (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
    special_in = req_op[2] && (b_zero_in || ovf_in);
    if (b_zero_in) begin
      early_data = req_op[1] ? req_a : '1;
    end else begin
      early_data = req_op[1] ? '0 : req_a;
    end
  end

  // One iteration step. lo holds the multiplier or the dividend/quotient, and acc
  // holds the partial product high half or the partial remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    if (op_q[2]) begin
      acc_n = div_ge ? (div_shift[XLEN-1:0] - b_mag_q) : div_shift[XLEN-1:0];
      lo_n  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_n = mul_sum[XLEN:1];
      lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {acc_n, lo_n};
    // The sign flags are already zero for unsigned operands, so a plain XOR covers every op.
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    quo_fix  = ((a_neg_q ^ b_neg_q) && !b_zero_q) ? -lo_n : lo_n;
    rem_fix  = a_neg_q ? -acc_n : acc_n;
    if (op_q[2]) begin
      final_data = op_q[1] ? rem_fix : quo_fix;
    end else begin
      final_data = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_data  <= '0;
    end else if (kill) begin
      state_q   <= StIdle;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_data  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q      <= req_op;
            b_mag_q   <= b_mag_in;
            a_neg_q   <= a_neg_in;
            b_neg_q   <= b_neg_in;
            b_zero_q  <= b_zero_in;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_q      <= a_mag_in;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (EARLY_OUT && special_in) begin
              state_q   <= StDone;
              rsp_valid <= 1'b1;
              rsp_data  <= early_data;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
            rsp_data  <= final_data;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
